move_scheduler: RTL and testbench
=================================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of 2, 2..16).
REQ-002 SHALL have parameter DROP_CNT_W, default 8, width of the overflow drop counter.
REQ-003 SHALL have port clk_in  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_in  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports a_valid_in / a_cmd_in  input  1 / 2  requester A (debounced buttons) command; encoding 00 fwd, 01 bwd, 10 leftRot, 11 rightRot.
REQ-006 SHALL have ports b_valid_in / b_cmd_in  input  1 / 2  requester B (remote/UART) command, same encoding.
REQ-007 SHALL have ports a_ready_out, b_ready_out  output  1 each  command accepted this cycle when valid and ready are both high.
REQ-008 SHALL have port frame_start_in  input  1  one-cycle pulse at the start of the vertical blanking interval.
REQ-009 SHALL have port mv_busy_in  input  1  movement datapath is updating pos/dir/plane.
REQ-010 SHALL have ports fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse  output  1 each  one-cycle, one-hot command to the movement datapath.
REQ-011 SHALL have ports fifo_full_out, fifo_empty_out  output  1 each  queue status.
REQ-012 SHALL have port drop_cnt_out  output  DROP_CNT_W  saturating count of commands lost to overflow.

Function
REQ-013 SHALL accept at most one command per cycle into a FIFO_DEPTH-entry FIFO.
REQ-014 SHALL arbitrate A vs B round-robin: on contention, grant the requester not granted last; with a single requester, grant it; initial priority after reset is A.
REQ-015 SHALL drive x_ready_out high only for the granted requester and only when the FIFO is not full or a pop occurs in the same cycle.
REQ-016 SHALL, when full and requester A is valid but not accepted, increment drop_cnt_out once per such cycle, saturating at all-ones; requester B stalls (no drop).
REQ-017 SHALL run a state machine IDLE -> WAIT_FRAME -> ISSUE -> SETTLE -> WAIT_DONE -> IDLE.
REQ-018 SHALL leave IDLE when FIFO is non-empty and mv_busy_in is low.
REQ-019 SHALL, in WAIT_FRAME, advance to ISSUE on frame_start_in high (see REQ-029/030).
REQ-020 SHALL, in ISSUE, pop the FIFO head and assert exactly one of the four pulses for exactly one cycle, per the command encoding.
REQ-021 SHALL spend exactly one cycle in SETTLE ignoring mv_busy_in, then enter WAIT_DONE.
REQ-022 SHALL, in WAIT_DONE, return to IDLE on the first cycle mv_busy_in is low.
REQ-023 SHALL issue at most one command per frame_start_in when frame sync is compiled in.
REQ-024 SHALL handle simultaneous push and pop in one cycle with no change in occupancy and no data loss, including when full.
REQ-025 SHALL keep all four pulse outputs low in every state other than ISSUE.

Reset
REQ-026 SHALL, on rst_in low, immediately and asynchronously clear FIFO pointers/occupancy, drop_cnt_out to 0, state to IDLE, round-robin priority to A, and all pulse outputs to 0.
REQ-027 SHALL, after reset, show fifo_empty_out=1, fifo_full_out=0, a_ready_out=b_ready_out=0 until the first cycle rst_in is high.
REQ-028 SHALL abandon any in-flight command when reset asserts mid-operation; no pulse SHALL be emitted for it after release.

Configuration
REQ-029 SHALL, with MOVE_SCHED_FRAME_SYNC_EN defined, wait in WAIT_FRAME for frame_start_in; a frame_start_in arriving in any other state is ignored.
REQ-030 SHALL, without MOVE_SCHED_FRAME_SYNC_EN, pass through WAIT_FRAME in one cycle without waiting; frame_start_in is unused.

Verification
REQ-031 SHALL cover: reset, A pushes 10, frame_start pulse, busy low -> leftRot_pulse high exactly one cycle, other pulses 0.
REQ-032 SHALL cover: A and B valid every cycle, cmds 00/11 -> grants alternate A,B,A,B; queue order matches grant order.
REQ-033 SHALL cover: depth 4, A pushes 6 commands with no frame_start -> fifo_full_out=1, drop_cnt_out=2, B ready low.
REQ-034 SHALL cover: mv_busy_in held high 10 cycles after issue -> next pulse no earlier than the cycle after busy falls (plus frame wait if enabled).
REQ-035 SHALL cover: rst_in low during WAIT_DONE with 3 queued -> empty FIFO, drop_cnt 0, no pulse after release.
REQ-036 SHALL cover: with macro undefined, 3 queued, busy low -> pulses 5 cycles apart without frame_start_in.

Source files
------------

// File: rtl/move_scheduler_if.sv
// Command/issue bundle between the movement requesters, the scheduler and the movement datapath.
// Signal names match the scheduler's pin list; clk/reset stay outside the bundle.
interface move_scheduler_if #(
  parameter int DROP_CNT_W = 8
);
  logic                  a_valid_in;
  logic [1:0]            a_cmd_in;
  logic                  a_ready_out;
  logic                  b_valid_in;
  logic [1:0]            b_cmd_in;
  logic                  b_ready_out;
  logic                  frame_start_in;
  logic                  mv_busy_in;
  logic                  fwd_pulse;
  logic                  bwd_pulse;
  logic                  leftRot_pulse;
  logic                  rightRot_pulse;
  logic                  fifo_full_out;
  logic                  fifo_empty_out;
  logic [DROP_CNT_W-1:0] drop_cnt_out;

  modport master (
    output a_valid_in, a_cmd_in, b_valid_in, b_cmd_in, frame_start_in, mv_busy_in,
    input  a_ready_out, b_ready_out, fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse,
    input  fifo_full_out, fifo_empty_out, drop_cnt_out
  );

  modport slave (
    input  a_valid_in, a_cmd_in, b_valid_in, b_cmd_in, frame_start_in, mv_busy_in,
    output a_ready_out, b_ready_out, fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse,
    output fifo_full_out, fifo_empty_out, drop_cnt_out
  );
endinterface

// File: rtl/move_scheduler.sv
// Round-robin command queue feeding one-hot move pulses to the movement datapath.
// Define MOVE_SCHED_FRAME_SYNC_EN to hold each issue until a frame_start_in pulse.
module move_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 8
) (
  input logic             clk_in,
  input logic             rst_in,
  move_scheduler_if.slave bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FRAME, S_ISSUE, S_SETTLE, S_WAIT_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  prio_a_q, prio_a_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic       full, empty, pop, push, space;
  logic       grant_a, grant_b, a_ready, b_ready;
  logic [1:0] push_cmd, head;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = (state_q == S_ISSUE);
  assign head  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign space   = !full || pop;
  assign grant_a = bus.a_valid_in && (!bus.b_valid_in || prio_a_q);
  assign grant_b = bus.b_valid_in && !grant_a;
  assign a_ready = grant_a && space && rst_in;
  assign b_ready = grant_b && space && rst_in;
  assign push    = a_ready || b_ready;
  assign push_cmd = a_ready ? bus.a_cmd_in : bus.b_cmd_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    prio_a_d = prio_a_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (a_ready)      prio_a_d = 1'b0;
    else if (b_ready) prio_a_d = 1'b1;
    // Only requester A loses commands; B is simply back-pressured.
    if (full && bus.a_valid_in && !a_ready && !(&drop_q))
      drop_d = drop_q + DROP_CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (!empty && !bus.mv_busy_in) state_d = S_WAIT_FRAME;
`ifdef MOVE_SCHED_FRAME_SYNC_EN
      S_WAIT_FRAME: if (bus.frame_start_in) state_d = S_ISSUE;
`else
      S_WAIT_FRAME: state_d = S_ISSUE;
`endif
      S_ISSUE:      state_d = S_SETTLE;
      S_SETTLE:     state_d = S_WAIT_DONE;
      S_WAIT_DONE:  if (!bus.mv_busy_in) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      prio_a_q <= 1'b1;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      prio_a_q <= prio_a_d;
      drop_q   <= drop_d;
    end
  end

  // Queue storage holds data only; validity is tracked by the pointers above.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= push_cmd;
  end

  assign bus.a_ready_out    = a_ready;
  assign bus.b_ready_out    = b_ready;
  assign bus.fwd_pulse      = pop && (head == 2'b00);
  assign bus.bwd_pulse      = pop && (head == 2'b01);
  assign bus.leftRot_pulse  = pop && (head == 2'b10);
  assign bus.rightRot_pulse = pop && (head == 2'b11);
  assign bus.fifo_full_out  = full;
  assign bus.fifo_empty_out = empty;
  assign bus.drop_cnt_out   = drop_q;
endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: scoreboard of expected issue order plus per-step checks.
module tb_move_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  logic prev_any = 1'b0;
  int   sb[$];
  int   pcyc[$];
  int   fall_cyc;
  int   pc0;

  move_scheduler_if #(.DROP_CNT_W(8)) bus();
  move_scheduler #(.FIFO_DEPTH(4), .DROP_CNT_W(8)) dut (
    .clk_in(clk), .rst_in(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse monitor: every pulse must be one-hot, single-cycle and match the scoreboard head.
  always @(negedge clk) begin
    logic [3:0] p;
    int got, exp;
    p = {bus.rightRot_pulse, bus.leftRot_pulse, bus.bwd_pulse, bus.fwd_pulse};
    if (p != 4'b0) begin
      pulse_cnt++;
      pcyc.push_back(cyc);
      check("pulse_onehot", $countones(p), 1);
      check("pulse_width", prev_any, 0);
      got = p[3] ? 3 : p[2] ? 2 : p[1] ? 1 : 0;
      check("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("pulse_cmd", got, exp);
      end
    end
    prev_any = |p;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.a_valid_in = 0; bus.a_cmd_in = 0;
    bus.b_valid_in = 0; bus.b_cmd_in = 0;
    bus.frame_start_in = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    sb.delete();
    repeat (2) tick();
    rst_n = 1;
  endtask

  task automatic push_a(input logic [1:0] cmd);
    bus.a_valid_in = 1; bus.a_cmd_in = cmd;
    sample();
    check("push_a_ready", bus.a_ready_out, 1);
    sb.push_back(int'(cmd));
    tick();
    bus.a_valid_in = 0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 120 && sb.size() != 0; i++) begin
      bus.frame_start_in = (i % 8 == 0);
      tick();
    end
    bus.frame_start_in = 0;
    check(tag, sb.size(), 0);
  endtask

  task automatic wait_pulse(input string tag);
    int start;
    start = pulse_cnt;
    for (int i = 0; i < 40 && pulse_cnt == start; i++) begin
      bus.frame_start_in = (i % 8 == 0);
      tick();
    end
    bus.frame_start_in = 0;
    check(tag, pulse_cnt != start, 1);
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    bus.mv_busy_in = 0;
    // Reset state, with A requesting while reset is held
    bus.a_valid_in = 1;
    sample();
    check("rst_a_ready", bus.a_ready_out, 0);
    check("rst_b_ready", bus.b_ready_out, 0);
    check("rst_empty", bus.fifo_empty_out, 1);
    check("rst_full", bus.fifo_full_out, 0);
    check("rst_drop", bus.drop_cnt_out, 0);
    tick();
    do_reset();

    // Single leftRot command
    push_a(2'b10);
    bus.frame_start_in = 1; tick(); bus.frame_start_in = 0;
    drain("t1_drain");
    sample();
    check("t1_empty", bus.fifo_empty_out, 1);

    // Round-robin contention A(00) vs B(11)
    do_reset();
    bus.mv_busy_in = 1;
    for (int k = 0; k < 4; k++) begin
      bus.a_valid_in = 1; bus.a_cmd_in = 2'b00;
      bus.b_valid_in = 1; bus.b_cmd_in = 2'b11;
      sample();
      check("rr_a_ready", bus.a_ready_out, (k % 2 == 0));
      check("rr_b_ready", bus.b_ready_out, (k % 2 == 1));
      sb.push_back((k % 2 == 0) ? 0 : 3);
      tick();
    end
    idle_inputs();
    sample();
    check("rr_full", bus.fifo_full_out, 1);
    bus.mv_busy_in = 0;
    drain("rr_drain");

    // Overflow: six A pushes into a depth-4 queue while movement is busy
    do_reset();
    bus.mv_busy_in = 1;
    for (int k = 0; k < 6; k++) begin
      bus.a_valid_in = 1; bus.a_cmd_in = 2'b01;
      sample();
      check("ovf_a_ready", bus.a_ready_out, (k < 4));
      if (k < 4) sb.push_back(1);
      tick();
    end
    bus.a_valid_in = 0;
    sample();
    check("ovf_full", bus.fifo_full_out, 1);
    check("ovf_empty", bus.fifo_empty_out, 0);
    check("ovf_drop", bus.drop_cnt_out, 2);
    tick();
    bus.b_valid_in = 1; bus.b_cmd_in = 2'b11;
    sample();
    check("ovf_b_ready", bus.b_ready_out, 0);
    tick();
    bus.b_valid_in = 0;
    sample();
    check("ovf_b_nodrop", bus.drop_cnt_out, 2);
    tick();
`ifndef MOVE_SCHED_FRAME_SYNC_EN
    // Push and pop in the same cycle while full
    bus.mv_busy_in = 0;
    tick();
    tick();
    bus.a_valid_in = 1; bus.a_cmd_in = 2'b11;
    sample();
    check("pp_a_ready", bus.a_ready_out, 1);
    check("pp_issue", bus.bwd_pulse, 1);
    sb.push_back(3);
    tick();
    bus.a_valid_in = 0;
    sample();
    check("pp_still_full", bus.fifo_full_out, 1);
    check("pp_drop", bus.drop_cnt_out, 2);
`endif
    bus.mv_busy_in = 0;
    drain("ovf_drain");

    // Busy held for 10 cycles after an issue
    do_reset();
    pcyc.delete();
    push_a(2'b00);
    wait_pulse("busy_first_pulse");
    bus.mv_busy_in = 1;
    push_a(2'b01);
    repeat (9) tick();
    bus.mv_busy_in = 0;
    fall_cyc = cyc;
    wait_pulse("busy_second_pulse");
    check("busy_after_fall", pcyc[pcyc.size()-1] > fall_cyc, 1);
`ifndef MOVE_SCHED_FRAME_SYNC_EN
    check("busy_latency", pcyc[pcyc.size()-1] - fall_cyc, 3);
`endif

    // Reset in WAIT_DONE with three commands queued
    do_reset();
    bus.mv_busy_in = 1;
    push_a(2'b00); push_a(2'b01); push_a(2'b10); push_a(2'b11);
    bus.mv_busy_in = 0;
    wait_pulse("mid_first_pulse");
    bus.mv_busy_in = 1;
    tick(); tick();
    check("mid_not_empty", bus.fifo_empty_out, 0);
    rst_n = 0;
    sb.delete();
    #1;
    check("mid_rst_empty", bus.fifo_empty_out, 1);
    check("mid_rst_full", bus.fifo_full_out, 0);
    check("mid_rst_drop", bus.drop_cnt_out, 0);
    tick();
    rst_n = 1;
    bus.mv_busy_in = 0;
    pc0 = pulse_cnt;
    for (int i = 0; i < 20; i++) begin
      bus.frame_start_in = (i % 4 == 0);
      tick();
    end
    bus.frame_start_in = 0;
    check("mid_no_pulse", pulse_cnt, pc0);
    check("mid_empty_after", bus.fifo_empty_out, 1);

`ifndef MOVE_SCHED_FRAME_SYNC_EN
    // Back-to-back issue spacing without frame sync
    do_reset();
    bus.mv_busy_in = 1;
    push_a(2'b00); push_a(2'b11); push_a(2'b01);
    pcyc.delete();
    bus.mv_busy_in = 0;
    drain("space_drain");
    check("space_count", pcyc.size(), 3);
    if (pcyc.size() == 3) begin
      check("space_gap1", pcyc[1] - pcyc[0], 5);
      check("space_gap2", pcyc[2] - pcyc[1], 5);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
